// File: rtl/mem_ctrl_pl_if.sv
// Request/response bundle between a bus slave front-end and the mem_ctrl_pl
// local data store.
//
// Handshake: a request (wr_rd_i, addr_i, wdata_i, wstrb_i) is transferred on
// a rising edge where valid_i && ready_o. The requester keeps the request
// fields stable while valid_i is high and ready_o is low. Read responses
// (rvalid_o, rdata_o, err_o) cannot be back-pressured.
interface mem_ctrl_pl_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  valid_i;
  logic                  ready_o;
  logic                  wr_rd_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [WIDTH-1:0]      wdata_i;
  logic [WIDTH/8-1:0]    wstrb_i;
  logic                  clr_i;
  logic [WIDTH-1:0]      rdata_o;
  logic                  rvalid_o;
  logic                  err_o;
  logic                  init_done_o;

  modport slave (
    input  valid_i, wr_rd_i, addr_i, wdata_i, wstrb_i, clr_i,
    output ready_o, rdata_o, rvalid_o, err_o, init_done_o
  );

  modport master (
    output valid_i, wr_rd_i, addr_i, wdata_i, wstrb_i, clr_i,
    input  ready_o, rdata_o, rvalid_o, err_o, init_done_o
  );
endinterface

// File: rtl/mem_ctrl_pl.sv
// Single-port synchronous memory with byte strobes, RD_LAT-deep read
// pipeline, out-of-range error reporting and a sequential zeroing sweep
// that runs after reset and on every soft clear.
module mem_ctrl_pl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LAT     = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mem_ctrl_pl_if.slave bus,
  output logic         state_dbg_o
);
  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  wr_err_q, wr_err_d;
  logic [RD_LAT-1:0]     pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0]     pipe_err_q, pipe_err_d;
  logic [WIDTH-1:0]      pipe_dat_q [RD_LAT];
  logic [WIDTH-1:0]      pipe_dat_d [RD_LAT];
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_wbe;
  logic                  run;
  logic                  in_range;
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;

  assign run      = (state_q == ST_RUN);
  assign in_range = ({1'b0, bus.addr_i} < DEPTH_W);
  // A clear in RUN wins over a request in the same cycle.
  assign accept   = run && !bus.clr_i && bus.valid_i;
  assign rd_acc   = accept && !bus.wr_rd_i;
  assign wr_acc   = accept && bus.wr_rd_i;

  assign bus.ready_o     = run && !bus.clr_i;
  assign bus.init_done_o = run;
  assign bus.rvalid_o    = pipe_vld_q[RD_LAT-1];
  assign bus.rdata_o     = pipe_dat_q[RD_LAT-1];
  assign bus.err_o       = wr_err_q | (pipe_vld_q[RD_LAT-1] & pipe_err_q[RD_LAT-1]);
  assign state_dbg_o     = run;

  // Next state, clear sweep and array write port (sweep and traffic never overlap).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wbe   = '0;
    wr_err_d  = wr_acc && !in_range;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wbe   = '1;
        if (clr_cnt_q == LAST_IDX) begin
          clr_cnt_d = '0;
          state_d   = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        if (bus.clr_i) begin
          state_d   = ST_INIT;
          clr_cnt_d = '0;
        end else if (wr_acc && in_range) begin
          mem_we    = 1'b1;
          mem_waddr = bus.addr_i;
          mem_wdata = bus.wdata_i;
          for (int b = 0; b < NB; b++) mem_wbe[8*b +: 8] = {8{bus.wstrb_i[b]}};
        end
      end
    endcase
  end

  // Read pipeline: stage 0 samples the array at the accepting edge; the last
  // stage is the output register and keeps its data between responses.
  always_comb begin
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_vld_d[i] = 1'b0;
      pipe_err_d[i] = 1'b0;
      pipe_dat_d[i] = '0;
    end
    pipe_vld_d[0] = rd_acc;
    pipe_err_d[0] = rd_acc && !in_range;
    pipe_dat_d[0] = (rd_acc && in_range) ? mem_q[bus.addr_i] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
    if (!pipe_vld_d[RD_LAT-1]) pipe_dat_d[RD_LAT-1] = pipe_dat_q[RD_LAT-1];
  end

  // Control and pipeline registers; reset empties the pipeline and restarts the sweep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      clr_cnt_q  <= '0;
      wr_err_q   <= 1'b0;
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_dat_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wr_err_q   <= wr_err_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_err_q <= pipe_err_d;
      for (int i = 0; i < RD_LAT; i++) pipe_dat_q[i] <= pipe_dat_d[i];
    end
  end

  // Storage array; contents are only cleared by the INIT sweep.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= (mem_q[mem_waddr] & ~mem_wbe) | (mem_wdata & mem_wbe);
  end
endmodule

// File: tb/tb_mem_ctrl_pl.sv
// Bench for mem_ctrl_pl (WIDTH 32, DEPTH 20, RD_LAT 3): directed scenarios
// followed by randomized traffic, all checked against a behavioural model.
module tb_mem_ctrl_pl;
  localparam int W      = 32;
  localparam int DEPTH  = 20;
  localparam int AW     = 5;
  localparam int RD_LAT = 3;

  logic clk;
  logic rst_n;
  logic state_dbg;

  mem_ctrl_pl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mem_ctrl_pl #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LAT(RD_LAT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model + scoreboard state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           init_left;
  logic [W-1:0] mmem [DEPTH];
  logic [W-1:0] last_rdata;
  logic [W-1:0] exp_q[$];
  int           exp_due_q[$];
  bit           exp_err_q[$];
  int           werr_due_q[$];
  int           log_cyc[$];
  logic [W-1:0] log_dat[$];
  bit           log_err[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    init_left  = DEPTH;
    last_rdata = '0;
    exp_q.delete();
    exp_due_q.delete();
    exp_err_q.delete();
    werr_due_q.delete();
    for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
  endtask

  // Behavioural model: ready after a DEPTH-edge sweep, a clear costs DEPTH+1
  // edges, reads answer RD_LAT-1 edges after the accepting edge.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      init_left = DEPTH;
    end else if (init_left > 0) begin
      init_left--;
    end else if (bus.clr_i) begin
      init_left = DEPTH;
      for (int a = 0; a < DEPTH; a++) mmem[a] = '0;
    end else if (bus.valid_i) begin
      if (int'(bus.addr_i) >= DEPTH) begin
        if (bus.wr_rd_i) werr_due_q.push_back(cyc);
        else begin
          exp_q.push_back('0); exp_due_q.push_back(cyc + RD_LAT - 1); exp_err_q.push_back(1'b1);
        end
      end else if (bus.wr_rd_i) begin
        for (int b = 0; b < W/8; b++)
          if (bus.wstrb_i[b]) mmem[bus.addr_i][8*b +: 8] = bus.wdata_i[8*b +: 8];
      end else begin
        exp_q.push_back(mmem[bus.addr_i]); exp_due_q.push_back(cyc + RD_LAT - 1);
        exp_err_q.push_back(1'b0);
      end
    end
  end

  // Compare process: every output against the model on every cycle.
  bit e_rv, e_err;
  always @(negedge clk) begin
    e_rv  = 1'b0;
    e_err = 1'b0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      e_rv       = 1'b1;
      e_err      = exp_err_q[0];
      last_rdata = exp_q[0];
      void'(exp_q.pop_front()); void'(exp_due_q.pop_front()); void'(exp_err_q.pop_front());
    end
    if (werr_due_q.size() > 0 && werr_due_q[0] == cyc) begin
      e_err = 1'b1;
      void'(werr_due_q.pop_front());
    end
    chk("rvalid", W'(bus.rvalid_o), W'(e_rv));
    chk("err", W'(bus.err_o), W'(e_err));
    chk("rdata", bus.rdata_o, last_rdata);
    chk("ready", W'(bus.ready_o), W'(rst_n && init_left == 0 && !bus.clr_i));
    chk("init_done", W'(bus.init_done_o), W'(rst_n && init_left == 0));
    if (bus.rvalid_o) begin
      log_cyc.push_back(cyc); log_dat.push_back(bus.rdata_o); log_err.push_back(bus.err_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.valid_i = 1'b0; bus.wr_rd_i = 1'b0; bus.addr_i = '0;
    bus.wdata_i = '0;   bus.wstrb_i = '0;   bus.clr_i  = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle request; returns at #1 after the accepting edge.
  task automatic req(input bit wr, input int addr, input logic [W-1:0] d, input logic [3:0] s);
    bus.valid_i = 1'b1; bus.wr_rd_i = wr; bus.addr_i = AW'(addr);
    bus.wdata_i = d;    bus.wstrb_i = s;
    @(posedge clk); #1;
    idle();
  endtask

  // Edges until ready_o is seen high, bounded.
  task automatic count_to_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.ready_o && n < 100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int n, n0, acc;
  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #22 rst_n = 1'b1;

    // Reset/init: ready after exactly DEPTH edges, every word reads 0.
    count_to_ready(n);
    chk("init_edges", W'(n), 32'd20);
    n0 = log_dat.size();
    for (int a = 0; a < DEPTH; a++) req(1'b0, a, '0, 4'h0);
    wait_cycles(RD_LAT + 1);
    chk("init_rd_count", W'(log_dat.size() - n0), 32'd20);
    for (int i = n0; i < log_dat.size(); i++) chk("init_rd_zero", log_dat[i], 32'h0);

    // Byte strobes.
    req(1'b1, 5, 32'hAABBCCDD, 4'hF);
    req(1'b1, 5, 32'h11223344, 4'b0101);
    n0 = log_dat.size();
    req(1'b0, 5, '0, 4'h0);
    wait_cycles(RD_LAT + 1);
    chk("strb_count", W'(log_dat.size() - n0), 32'd1);
    chk("strb_data", log_dat[n0], 32'hAA22CC44);

    // Streaming: 8 writes then 8 back-to-back reads.
    for (int i = 0; i < 8; i++) req(1'b1, i, 32'(i) * 32'h01010101, 4'hF);
    n0 = log_dat.size();
    for (int i = 0; i < 8; i++) begin
      bus.valid_i = 1'b1; bus.wr_rd_i = 1'b0; bus.addr_i = AW'(i);
      @(posedge clk); #1;
      if (i == 0) acc = cyc;
    end
    idle();
    wait_cycles(RD_LAT + 2);
    chk("stream_count", W'(log_dat.size() - n0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("stream_data", log_dat[n0+i], 32'(i) * 32'h01010101);
      chk("stream_cycle", W'(log_cyc[n0+i]), W'(acc + 2 + i));
    end

    // Async reset in the middle of a read stream.
    for (int i = 1; i <= 5; i++) begin
      bus.valid_i = 1'b1; bus.wr_rd_i = 1'b0; bus.addr_i = AW'(i);
      @(posedge clk); #1;
    end
    chk("pre_rst_rvalid", W'(bus.rvalid_o), 32'd1);
    #2 rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    chk("rst_rvalid", W'(bus.rvalid_o), 32'd0);
    chk("rst_ready", W'(bus.ready_o), 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_err", W'(bus.err_o), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    count_to_ready(n);
    chk("reinit_edges", W'(n), 32'd20);

    // Out-of-range read and write.
    req(1'b1, 11, 32'h0B0B0B0B, 4'hF);
    n0 = log_dat.size();
    req(1'b0, 25, '0, 4'h0);
    wait_cycles(3);
    req(1'b1, 31, 32'hFFFFFFFF, 4'hF);
    chk("oor_wr_err", W'(bus.err_o), 32'd1);
    chk("oor_wr_rvalid", W'(bus.rvalid_o), 32'd0);
    req(1'b0, 11, '0, 4'h0);
    wait_cycles(RD_LAT + 1);
    chk("oor_count", W'(log_dat.size() - n0), 32'd2);
    chk("oor_rd_data", log_dat[n0], 32'h0);
    chk("oor_rd_err", W'(log_err[n0]), 32'd1);
    chk("alias_data", log_dat[n0+1], 32'h0B0B0B0B);
    chk("alias_err", W'(log_err[n0+1]), 32'd0);

    // Soft clear with a competing request and an in-flight read.
    for (int a = 0; a < DEPTH; a++) req(1'b1, a, 32'h5A000000 | 32'(a), 4'hF);
    n0 = log_dat.size();
    req(1'b0, 3, '0, 4'h0);
    bus.clr_i = 1'b1; bus.valid_i = 1'b1; bus.addr_i = AW'(4);
    @(posedge clk); #1;
    idle();
    n = 1;
    while (!bus.ready_o && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("clr_edges", W'(n), 32'd21);
    chk("clr_inflight_count", W'(log_dat.size() - n0), 32'd1);
    chk("clr_inflight_data", log_dat[n0], 32'h5A000003);
    n0 = log_dat.size();
    for (int a = 0; a < DEPTH; a++) req(1'b0, a, '0, 4'h0);
    wait_cycles(RD_LAT + 1);
    chk("clr_rd_count", W'(log_dat.size() - n0), 32'd20);
    for (int i = n0; i < log_dat.size(); i++) chk("clr_rd_zero", log_dat[i], 32'h0);

    // Randomized traffic, including out-of-range addresses and clears.
    repeat (400) begin
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.wr_rd_i = 1'($urandom_range(0, 1));
      bus.addr_i  = AW'($urandom_range(0, 31));
      bus.wdata_i = $urandom;
      bus.wstrb_i = 4'($urandom_range(0, 15));
      bus.clr_i   = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    idle();
    wait_cycles(RD_LAT + 3);
    chk("drain_empty", W'(exp_q.size() + werr_due_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_pl.md
# mem_ctrl_pl

Parametrised single-port synchronous memory with valid/ready request handshake, per-byte write strobes, configurable read latency, out-of-range error reporting and a sequential self-clear engine. It is the next generation of the team's simple register-array memory and sits behind a bus slave as the local data store. After reset or on a clear request, it zeroes every word before it accepts traffic.

## Interface
- WIDTH, 32: data width in bits; must be a multiple of 8.
- DEPTH, 32: number of words; any value ≥ 2, not necessarily a power of two.
- ADDR_WIDTH, $clog2(DEPTH): address port width.
- RD_LAT, 1: read latency in cycles; legal range 1..4.

- clk_i  in  1  single clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  request ready; a request is accepted on a rising edge where valid_i && ready_o.
- wr_rd_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  word address.
- wdata_i  in  WIDTH  write data.
- wstrb_i  in  WIDTH/8  byte write enables; bit b covers wdata_i[8b+7:8b].
- clr_i  in  1  soft clear request; level-sampled.
- rdata_o  out  WIDTH  read data; valid only while rvalid_o = 1.
- rvalid_o  out  1  one-cycle read-response strobe.
- err_o  out  1  one-cycle error strobe for an out-of-range access.
- init_done_o  out  1  high while in RUN.

## Operation
- States: INIT and RUN. An internal clear counter clr_cnt runs 0..DEPTH-1.
- Reset (rst_ni = 0, asynchronous) forces:
  - state = INIT, clr_cnt = 0.
  - ready_o = 0, rdata_o = 0, rvalid_o = 0, err_o = 0, init_done_o = 0.
  - The read pipeline is emptied.
  - Array contents are not reset directly; the INIT sweep clears them.
- INIT:
  - Each edge writes mem[clr_cnt] = 0 and increments clr_cnt.
  - At clr_cnt = DEPTH-1 the edge writes the last word, sets clr_cnt = 0 and moves to RUN.
  - ready_o = 0 throughout INIT.
- RUN:
  - ready_o = ~clr_i (combinational); init_done_o = 1.
  - If clr_i = 1, the next edge moves to INIT with clr_cnt = 0. clr_i has priority over any valid_i in the same cycle; that request is not accepted.
- Accepted write, addr_i < DEPTH:
  - For each b with wstrb_i[b] = 1, mem[addr_i] byte b takes the new value at the accepting edge.
  - wstrb_i = 0 is a legal no-op.
  - No response strobe.
- Accepted read, addr_i < DEPTH:
  - Data is sampled from the array at the accepting edge and enters an RD_LAT-deep pipeline.
- Out-of-range access (addr_i ≥ DEPTH):
  - No array change.
  - A read returns rdata_o = 0 with rvalid_o = 1 and err_o = 1 together, on the normal read schedule.
  - A write pulses err_o alone for one cycle, one cycle after acceptance.
  - If a write error and a read response would land on the same cycle, err_o is the OR of both.
- Reads already accepted before a clr_i or an INIT entry still complete with their captured data. Reset discards them.
- Between responses, rdata_o holds its last value and rvalid_o = 0. There is no read back-pressure.

## Timing
- Throughput: one request per cycle in RUN. Any mix of reads and writes can go back to back.
- Read latency: for a read accepted at edge k, rvalid_o and rdata_o are high/valid in the cycle after edge k+RD_LAT-1. With RD_LAT = 1, the response appears immediately after the accepting edge.
- Read-after-write: a write at edge k followed by a read of the same address at edge k+1 returns the new data.
- Init duration: after rst_ni deasserts, ready_o first rises after the DEPTH-th rising edge. After clr_i is sampled, ready_o returns DEPTH+1 edges later, counting the transition edge.
- clr_i held high: the block re-enters INIT only from RUN. During INIT, clr_i is ignored; the sweep is not restarted.
- Reset mid-INIT or mid-read: outputs go to their reset values immediately (asynchronously). After release, the full INIT sweep is redone.

## Test plan
- Reset/init: release rst_ni with DEPTH = 32 → ready_o = 0 for 32 edges, then 1; read every address → all 0x00000000, rvalid_o pulses each read, err_o = 0.
- Byte strobes: write 0xAABBCCDD to addr 5 with wstrb 0xF, then 0x11223344 with wstrb 0b0101 → read addr 5 returns 0xAA22CC44.
- Latency/streaming: RD_LAT = 3; write addr i = i*0x01010101 for i = 0..7, then issue 8 back-to-back reads → 8 consecutive rvalid_o pulses, the first 3 cycles after the first acceptance, data in order.
- Out of range: DEPTH = 20; read addr 25 → rvalid_o = 1, err_o = 1, rdata_o = 0. Write addr 31 → err_o pulse only, and addr 31 mod 20 = addr 11 is unchanged.
- Soft clear: fill memory, assert clr_i for 1 cycle while valid_i = 1 → request not accepted, ready_o low for DEPTH+1 edges, then all reads return 0. A read accepted before clr_i still returns the old data.
- Async reset mid-traffic: pull rst_ni low between clock edges during a streaming read → rvalid_o, ready_o and rdata_o drop to 0 immediately, and a fresh INIT follows release.
